// File: rtl/conv_sched.sv
// 1-D convolution sequencer: loads K weights, runs the MAC over the input SRAM,
// writes saturated results to the output SRAM, then streams them to the UART.
module conv_sched #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 8,
    parameter int K     = 3,
    parameter int ACCW  = 19
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          in_rd_en,
    output logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_rdata,
    output logic          w_rd_en,
    output logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_rdata,
    output logic          out_wr_en,
    output logic          out_rd_en,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_wdata,
    input  logic [DW-1:0] out_rdata,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ready
);

    localparam int            CW    = 4;
    localparam logic [CW-1:0] KC    = CW'(K);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, LOADW, MAC, WR, DUMP, TXW, TXH} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [AW-1:0]       o_idx;
    logic [AW-1:0]       d_idx;
    logic [DW-1:0]       w_reg [K];
    logic [ACCW-1:0]     acc;
    logic [AW:0]         tap_addr;
    logic                w_vld_p0;
    logic                vld_p0;
    logic [CW-1:0]       tap_p0;
    logic [DW-1:0]       w_sel;
    logic [2*DW-1:0]     prod;

    function automatic logic [DW-1:0] sat_u(input logic [ACCW-1:0] a);
        if (a > ACCW'({DW{1'b1}}))
            return {DW{1'b1}};
        return a[DW-1:0];
    endfunction

    // o+k kept one bit wider so taps past the end are dropped, never wrapped
    assign tap_addr = {1'b0, o_idx} + (AW + 1)'(cnt);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        in_rd_en  = 1'b0;
        in_addr   = '0;
        w_rd_en   = 1'b0;
        w_addr    = '0;
        out_wr_en = 1'b0;
        out_rd_en = 1'b0;
        out_addr  = '0;
        out_wdata = '0;
        tx_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = LOADW;
            end
            LOADW: begin
                if (cnt < KC) begin
                    w_rd_en = 1'b1;
                    w_addr  = AW'(cnt);
                end else begin
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (cnt < KC) begin
                    if (tap_addr < DEPTH_X) begin
                        in_rd_en = 1'b1;
                        in_addr  = tap_addr[AW-1:0];
                    end
                end else begin
                    state_nxt = WR;
                end
            end
            WR: begin
                out_wr_en = 1'b1;
                out_addr  = o_idx;
                out_wdata = sat_u(acc);
                state_nxt = (o_idx == LAST) ? DUMP : MAC;
            end
            DUMP: begin
                out_rd_en = 1'b1;
                out_addr  = d_idx;
                state_nxt = TXW;
            end
            TXW: begin
                state_nxt = TXH;
            end
            TXH: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    if (d_idx == LAST) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DUMP;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < K; i++)
            if (tap_p0 == CW'(i))
                w_sel = w_reg[i];
    end

    assign prod = {{DW{1'b0}}, in_rdata} * {{DW{1'b0}}, w_sel};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            o_idx    <= '0;
            d_idx    <= '0;
            acc      <= '0;
            w_vld_p0 <= 1'b0;
            vld_p0   <= 1'b0;
            tap_p0   <= '0;
            tx_data  <= '0;
            for (int i = 0; i < K; i++)
                w_reg[i] <= '0;
        end else begin
            // p0: read issued last cycle, SRAM data valid now
            w_vld_p0 <= w_rd_en;
            vld_p0   <= in_rd_en;
            tap_p0   <= cnt;
            for (int i = 0; i < K; i++)
                if (w_vld_p0 && tap_p0 == CW'(i))
                    w_reg[i] <= w_rdata;

            if (state == WR)
                acc <= '0;
            else if (vld_p0)
                acc <= acc + ACCW'(prod);

            if ((state == LOADW || state == MAC) && state_nxt == state)
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;

            if (state == IDLE)
                o_idx <= '0;
            else if (state == WR)
                o_idx <= o_idx + AW'(1);

            if (state == IDLE)
                d_idx <= '0;
            else if (state == TXH && tx_ready)
                d_idx <= d_idx + AW'(1);

            if (state == TXW)
                tx_data <= out_rdata;
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// Randomized bench for conv_sched: SRAM/UART responders plus a direct
// convolution reference computed from the memory images.
module tb_conv_sched;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int K     = 3;
    localparam int ACCW  = 19;
    localparam int LAT   = (K + 1) + DEPTH * (K + 2);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          busy, done;
    logic          in_rd_en, w_rd_en, out_wr_en, out_rd_en;
    logic [AW-1:0] in_addr, w_addr, out_addr;
    logic [DW-1:0] in_rdata, w_rdata, out_rdata, out_wdata;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;

    conv_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .K(K), .ACCW(ACCW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .in_rd_en(in_rd_en), .in_addr(in_addr), .in_rdata(in_rdata),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .out_wr_en(out_wr_en), .out_rd_en(out_rd_en), .out_addr(out_addr),
        .out_wdata(out_wdata), .out_rdata(out_rdata),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] in_mem  [DEPTH];
    logic [DW-1:0] w_mem   [DEPTH];
    logic [DW-1:0] out_mem [DEPTH];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_wr = -1;
    int wr_cnt, done_cnt, hold_err, conflict, stall_cnt;
    int rdy_mode = 0;
    int uart_q[$];
    logic          prev_valid = 1'b0;
    logic          prev_hs = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_out(input int o);
        int s = 0;
        for (int k = 0; k < K; k++)
            if (o + k < DEPTH)
                s += int'(in_mem[o + k]) * int'(w_mem[k]);
        return (s > 255) ? 255 : s;
    endfunction

    // SRAM responders, 1-cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_rd_en)  in_rdata  <= in_mem[in_addr];
        if (w_rd_en)   w_rdata   <= w_mem[w_addr];
        if (out_rd_en) out_rdata <= out_mem[out_addr];
        if (out_wr_en) out_mem[out_addr] <= out_wdata;
    end

    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ($urandom_range(0, 3) != 0);
            default: tx_ready = !(uart_q.size() == 5 && stall_cnt < 10);
        endcase
    end

    always @(negedge clk) begin
        if (start && !busy) start_cyc = cyc;
        if (out_wr_en) begin
            wr_cnt++;
            last_wr = cyc;
        end
        if (out_wr_en && out_rd_en) conflict++;
        if (done) done_cnt++;
        if (tx_valid && !tx_ready && uart_q.size() == 5) stall_cnt++;
        if (prev_valid && !prev_hs && (!tx_valid || tx_data != prev_data)) hold_err++;
        if (tx_valid && tx_ready) uart_q.push_back(int'(tx_data));
        prev_valid = tx_valid && reset_n;
        prev_hs    = tx_valid && tx_ready;
        prev_data  = tx_data;
    end

    task automatic set_w(input int a, input int b, input int c);
        for (int i = 0; i < DEPTH; i++) w_mem[i] = DW'($urandom);
        w_mem[0] = DW'(a);
        w_mem[1] = DW'(b);
        w_mem[2] = DW'(c);
    endtask

    task automatic set_in(input int mode, input int v);
        for (int i = 0; i < DEPTH; i++)
            in_mem[i] = (mode == 0) ? DW'(v) : (mode == 1) ? DW'(i) : DW'($urandom);
    endtask

    task automatic clear_stats();
        wr_cnt = 0; done_cnt = 0; hold_err = 0; conflict = 0; stall_cnt = 0;
        last_wr = -1;
        uart_q.delete();
        for (int i = 0; i < DEPTH; i++) out_mem[i] = DW'($urandom);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic do_run(input string name, input int poke, input int budget);
        clear_stats();
        pulse_start();
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            @(posedge clk); #1;
            start = poke != 0 && (cyc == start_cyc + 50 || cyc == start_cyc + 400);
        end
        start = 1'b0;
        if (done_cnt == 0) chk({name, "_timeout"}, 0, 1);
        repeat (5) @(posedge clk);
        #1;
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_wr_cnt"}, wr_cnt, DEPTH);
        chk({name, "_latency"}, last_wr - start_cyc, LAT);
        chk({name, "_busy_end"}, busy, 0);
        chk({name, "_hold"}, hold_err, 0);
        chk({name, "_conflict"}, conflict, 0);
        chk({name, "_bytes"}, uart_q.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("%s_out[%0d]", name, i), out_mem[i], ref_out(i));
            if (i < uart_q.size())
                chk($sformatf("%s_tx[%0d]", name, i), uart_q[i], ref_out(i));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        tx_ready = 1'b1;
        set_w(0, 0, 0);
        set_in(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {busy, done, in_rd_en, w_rd_en, out_wr_en, out_rd_en, tx_valid,
                         in_addr, w_addr, out_addr, out_wdata, tx_data}, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);

        rdy_mode = 0;
        set_w(1, 2, 3);     set_in(0, 1);   do_run("ones", 0, 3000);
        chk("ones_62", out_mem[62], 3);
        chk("ones_63", out_mem[63], 1);
        set_w(1, 0, 0);     set_in(1, 0);   do_run("ramp", 0, 3000);
        set_w(255, 255, 255); set_in(0, 255); do_run("sat", 0, 3000);
        set_w(0, 0, 0);     set_in(2, 0);   do_run("zero", 0, 3000);

        rdy_mode = 2;
        set_w(int'($urandom_range(0, 255)), int'($urandom_range(0, 40)), 1);
        set_in(2, 0);
        do_run("stall", 0, 3000);
        chk("stall_cycles", stall_cnt, 10);

        rdy_mode = 1;
        for (int t = 0; t < 3; t++) begin
            set_w(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)));
            set_in(2, 0);
            do_run($sformatf("rand%0d", t), 0, 6000);
        end
        set_w(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 20)));
        set_in(2, 0);
        do_run("poke", 1, 6000);

        // abort mid-MAC, then confirm a clean rerun
        rdy_mode = 0;
        set_w(3, 1, 2);
        set_in(2, 0);
        clear_stats();
        pulse_start();
        for (int i = 0; i < 500 && cyc < start_cyc + K + 2 + 100; i++) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_outs", {busy, done, in_rd_en, w_rd_en, out_wr_en, out_rd_en, tx_valid,
                           in_addr, w_addr, out_addr, out_wdata, tx_data}, 0);
        chk("abort_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_done", done_cnt, 0);
        chk("abort_wr_cnt", wr_cnt, 20);
        do_run("rerun", 0, 3000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
- Sequencer for the 1-D convolution datapath between the input, weight and output SRAMs (DEPTH entries each) and the UART transmitter.
- On `start`, loads K weights into internal registers and computes out[o] = sat8(sum_{k<K} in[o+k]*w[k]) for o = 0..DEPTH-1. Input reads with o+k >= DEPTH contribute 0.
- Writes each result to the output SRAM, then streams the output SRAM to the UART as one byte per entry through a valid/ready handshake.

Parameters:
DEPTH, 64, entries per SRAM
AW, 6, address width (log2 DEPTH)
DW, 8, data width, unsigned
K, 3, number of taps (1..8)
ACCW, 19, accumulator width (2*DW+3)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a run; ignored unless in IDLE
busy  out  1  high in every state except IDLE
done  out  1  single-cycle pulse when the last UART byte is accepted
in_rd_en  out  1  input SRAM read strobe
in_addr  out  AW  input SRAM address
in_rdata  in  DW  input SRAM data; valid the cycle after in_rd_en
w_rd_en  out  1  weight SRAM read strobe
w_addr  out  AW  weight SRAM address
w_rdata  in  DW  weight data; valid the cycle after w_rd_en
out_wr_en  out  1  output SRAM write strobe
out_rd_en  out  1  output SRAM read strobe
out_addr  out  AW  output SRAM address, shared by reads and writes
out_wdata  out  DW  output SRAM write data
out_rdata  in  DW  output SRAM read data; 1-cycle latency
tx_valid  out  1  byte available to the UART
tx_data  out  DW  byte to transmit
tx_ready  in  1  UART accepts the byte when tx_valid && tx_ready

Behaviour:
- Reset (async assert, sync deassert is external): all outputs 0, state IDLE, accumulator and weight registers 0. Asserting reset_n low mid-run aborts immediately; done is not pulsed; SRAM contents are untouched.
- States:
  - IDLE: waits for start.
  - LOADW: K+1 cycles. Issues w_rd_en at addresses 0..K-1 on consecutive cycles, capturing each w_rdata one cycle later.
  - MAC: per output o, K issue cycles (cycle k: in_rd_en=1, in_addr=o+k if o+k<DEPTH, else in_rd_en=0 and the tap contributes 0), then 1 drain cycle for the last product.
  - WR: 1 cycle. out_wr_en=1, out_addr=o, out_wdata = 255 if acc > 255 else acc[7:0]. Accumulator clears. Goes to MAC with o+1, or to DUMP when o = DEPTH-1.
  - DUMP: issues out_rd_en for address d.
  - TXW: next cycle, latches out_rdata into tx_data and raises tx_valid.
  - TXH: holds tx_valid/tx_data stable until tx_ready. On the handshake cycle, drops tx_valid. If d = DEPTH-1, pulses done and goes to IDLE; otherwise increments d and returns to DUMP.
- Conv latency: (K+1) + DEPTH*(K+2) cycles from the cycle after start to the last out_wr_en. With defaults: 4 + 64*5 = 324.
- Arithmetic: products are unsigned DW x DW. The accumulator is ACCW wide and cannot overflow for K <= 8. Saturation is applied only at write.
- Address arithmetic: o+k is computed AW+1 wide, so there is no wrap-around. An out-of-range tap is a zero contribution, never address (o+k) mod DEPTH.
- start while busy is ignored; no re-queue.
- At most one SRAM strobe of each kind is high per cycle. out_rd_en and out_wr_en are never high together.
- Lowering tx_ready never causes tx_data to change while tx_valid is high.

Test Plan:
- w = {1,2,3}, in[i] = 1 for all i, start → out[0..61] = 6, out[62] = 3, out[63] = 1; UART bytes are 6 (x62), 3, 1 in order; done pulses exactly once.
- w = {1,0,0}, in[i] = i → out[i] = i; UART emits bytes 0..63 in ascending order; last out_wr_en occurs 324 cycles after the start cycle.
- w = {255,255,255}, in[i] = 255 → every out = 255 (saturated); w = {0,0,0} → every out = 0.
- tx_ready held low for 10 cycles on byte 5 → tx_valid stays 1 and tx_data stays constant for all 10 cycles; no byte is lost or duplicated across all 64.
- Pulse reset_n low at cycle 100 of the MAC phase → all outputs 0 within the same cycle, busy = 0, no done; a subsequent start reproduces the full correct result.
- start pulsed again while busy → no effect; exactly 64 writes and 64 UART bytes result.
